sync_fifo_ctrl: RTL and testbench
=================================

SYNC_FIFO_CTRL -- requirements
Module: sync_fifo_ctrl

Interface
REQ-001 SHALL have parameter P_DATA_WIDTH, default 8, the FIFO word width.
REQ-002 SHALL have parameter P_ADDR_WIDTH, default 4, the RAM address width; DEPTH = 2**P_ADDR_WIDTH.
REQ-003 SHALL have port clk_i, input, 1, the single clock; all logic on the rising edge.
REQ-004 SHALL have port rst_ni, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port flush_i, input, 1, synchronous clear of all FIFO contents.
REQ-006 SHALL have port in_valid_i, input, 1, write request.
REQ-007 SHALL have port in_data_i, input, P_DATA_WIDTH, write data.
REQ-008 SHALL have port in_ready_o, output, 1, FIFO can accept a word.
REQ-009 SHALL have port out_valid_o, output, 1, head word present on out_data_o.
REQ-010 SHALL have port out_ready_i, input, 1, consumer takes the head word.
REQ-011 SHALL have port out_data_o, output, P_DATA_WIDTH, head word, a combinational pass-through of ram_data_i.
REQ-012 SHALL have port count_o, output, P_ADDR_WIDTH+1, number of stored words.
REQ-013 SHALL have port ovf_o, output, 1, sticky error: push attempted while full.
REQ-014 SHALL have port ram_wr_o, output, 1, RAM write enable.
REQ-015 SHALL have port ram_addr_wr_o, output, P_ADDR_WIDTH, RAM write address.
REQ-016 SHALL have port ram_data_wr_o, output, P_DATA_WIDTH, RAM write data, equal to in_data_i.
REQ-017 SHALL have port ram_rd_o, output, 1, RAM read enable (fetch).
REQ-018 SHALL have port ram_addr_rd_o, output, P_ADDR_WIDTH, RAM read address.
REQ-019 SHALL have port ram_data_i, input, P_DATA_WIDTH, RAM registered read data, with one-cycle latency, held while ram_rd_o=0.

Function
REQ-020 SHALL keep the following state:
- wr_ptr and rd_ptr, P_ADDR_WIDTH bits each, wrapping modulo DEPTH;
- ram_cnt, P_ADDR_WIDTH+1 bits, the words in RAM not yet fetched;
- out_valid, a flag meaning ram_data_i holds an unconsumed head word.
REQ-021 SHALL drive count_o = ram_cnt + out_valid, and SHALL keep count_o <= DEPTH at all times.
REQ-022 SHALL drive in_ready_o = (count_o < DEPTH) from registered state only, with no same-cycle pop bypass.
REQ-023 SHALL define push = in_valid_i & in_ready_o & ~flush_i. On push: ram_wr_o=1, ram_addr_wr_o=wr_ptr, and wr_ptr increments.
REQ-024 SHALL define pop = out_valid & out_ready_i & ~flush_i, and SHALL drive out_valid_o = out_valid.
REQ-025 SHALL define fetch = (ram_cnt != 0) & (~out_valid | out_ready_i) & ~flush_i. On fetch: ram_rd_o=1, ram_addr_rd_o=rd_ptr, and rd_ptr increments.
REQ-026 SHALL update ram_cnt as ram_cnt + push - fetch, and out_valid as fetch | (out_valid & ~pop).
REQ-027 SHALL never fetch a word written in the same cycle, since fetch requires ram_cnt != 0 from registered state; read and write addresses SHALL therefore never collide.
REQ-028 SHALL have write-to-out_valid_o latency of 2 cycles on an empty FIFO: push in cycle t, fetch in t+1, out_valid_o=1 in t+2.
REQ-029 SHALL sustain one push and one pop per cycle in steady state, with no bubbles.
REQ-030 SHALL give flush_i priority over push, pop and fetch in the same cycle. On flush, the following SHALL all clear to 0 next cycle: pointers, ram_cnt, out_valid and ovf_o.
REQ-031 SHALL set ovf_o on in_valid_i & ~in_ready_o & ~flush_i, and hold it until flush or reset; a refused push SHALL NOT modify any state.
REQ-032 SHALL keep out_valid_o=0 in every cycle with out_ready_i=1 and an empty FIFO; no pop occurs and no error is flagged.
REQ-033 SHALL assume the RAM uses one clock, has a registered read and no read-during-write forwarding; no other RAM behaviour is relied on.

Reset
REQ-034 SHALL, on rst_ni=0, asynchronously clear wr_ptr, rd_ptr, ram_cnt, out_valid and ovf_o to 0.
REQ-035 SHALL hold the following values during reset: in_ready_o=1, out_valid_o=0, count_o=0, ram_wr_o=0, ram_rd_o=0.
REQ-036 SHALL discard any word in flight when reset asserts mid-operation, and SHALL accept a push in the first cycle after rst_ni rises.

Verification
REQ-037 SHALL verify fill latency: DEPTH=16, push 0xA5 at cycle t -> ram_wr_o=1 with addr 0 at t; ram_rd_o=1 with addr 0 at t+1; out_valid_o=1, out_data_o=0xA5 and count_o=1 at t+2.
REQ-038 SHALL verify full: push 16 words with out_ready_i=0 -> count_o=16 and in_ready_o=0; a 17th push sets ovf_o=1 with count_o unchanged.
REQ-039 SHALL verify streaming: continuous push and pop of 0..99 -> output sequence 0..99 in order with no gaps after the first word, and count_o stable at 1 or 2.
REQ-040 SHALL verify wrap-around: 40 words through DEPTH=16 with random valid/ready -> data order preserved, and pointers wrap 15->0 without loss.
REQ-041 SHALL verify flush: flush_i with count_o=5 and push asserted -> next cycle count_o=0, out_valid_o=0, ovf_o=0, and the pushed word is dropped.
REQ-042 SHALL verify reset: rst_ni low mid-stream -> outputs take REQ-035 values immediately; after release, push 0x3C -> out_data_o=0x3C two cycles later.

Source files
------------

// File: rtl/sync_fifo_ctrl.sv
// Synchronous FIFO controller driving an external RAM with registered read.
// The head word lives in the RAM output register; out_valid tracks whether it is unconsumed.
module sync_fifo_ctrl #(
  parameter int P_DATA_WIDTH = 8,
  parameter int P_ADDR_WIDTH = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    flush_i,
  input  logic                    in_valid_i,
  input  logic [P_DATA_WIDTH-1:0] in_data_i,
  output logic                    in_ready_o,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [P_DATA_WIDTH-1:0] out_data_o,
  output logic [P_ADDR_WIDTH:0]   count_o,
  output logic                    ovf_o,
  output logic                    ram_wr_o,
  output logic [P_ADDR_WIDTH-1:0] ram_addr_wr_o,
  output logic [P_DATA_WIDTH-1:0] ram_data_wr_o,
  output logic                    ram_rd_o,
  output logic [P_ADDR_WIDTH-1:0] ram_addr_rd_o,
  input  logic [P_DATA_WIDTH-1:0] ram_data_i
);

  localparam logic [P_ADDR_WIDTH:0] DEPTH_C = (P_ADDR_WIDTH+1)'(2**P_ADDR_WIDTH);

  logic [P_ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [P_ADDR_WIDTH:0]   ram_cnt_q, ram_cnt_d;
  logic                    out_valid_q, out_valid_d;
  logic                    ovf_q, ovf_d;
  logic                    push, pop, fetch;

  assign count_o     = ram_cnt_q + {{P_ADDR_WIDTH{1'b0}}, out_valid_q};
  assign in_ready_o  = (count_o < DEPTH_C);
  assign out_valid_o = out_valid_q;
  assign out_data_o  = ram_data_i;
  assign ovf_o       = ovf_q;

  // rst_ni gates push so no RAM write escapes while reset is held.
  assign push  = rst_ni & in_valid_i & in_ready_o & ~flush_i;
  assign pop   = out_valid_q & out_ready_i & ~flush_i;
  assign fetch = (ram_cnt_q != '0) & (~out_valid_q | out_ready_i) & ~flush_i;

  assign ram_wr_o      = push;
  assign ram_addr_wr_o = wr_ptr_q;
  assign ram_data_wr_o = in_data_i;
  assign ram_rd_o      = fetch;
  assign ram_addr_rd_o = rd_ptr_q;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    ram_cnt_d   = ram_cnt_q;
    out_valid_d = out_valid_q;
    ovf_d       = ovf_q;
    if (flush_i) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      ram_cnt_d   = '0;
      out_valid_d = 1'b0;
      ovf_d       = 1'b0;
    end else begin
      if (push)  wr_ptr_d = wr_ptr_q + P_ADDR_WIDTH'(1);
      if (fetch) rd_ptr_d = rd_ptr_q + P_ADDR_WIDTH'(1);
      case ({push, fetch})
        2'b10:   ram_cnt_d = ram_cnt_q + (P_ADDR_WIDTH+1)'(1);
        2'b01:   ram_cnt_d = ram_cnt_q - (P_ADDR_WIDTH+1)'(1);
        default: ram_cnt_d = ram_cnt_q;
      endcase
      out_valid_d = fetch | (out_valid_q & ~pop);
      if (in_valid_i & ~in_ready_o) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      ram_cnt_q   <= '0;
      out_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      ram_cnt_q   <= ram_cnt_d;
      out_valid_q <= out_valid_d;
      ovf_q       <= ovf_d;
    end
  end

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Bench for sync_fifo_ctrl: RAM model plus a queue-based reference of FIFO contents.
module tb_sync_fifo_ctrl;
  localparam int DW = 8;
  localparam int AW = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          out_ready = 1'b0;
  logic          in_ready, out_valid, ovf, ram_wr, ram_rd;
  logic [DW-1:0] out_data, ram_data_wr;
  logic [AW:0]   count;
  logic [AW-1:0] ram_addr_wr, ram_addr_rd;
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] ram_q;

  always #5 clk = ~clk;

  sync_fifo_ctrl #(.P_DATA_WIDTH(DW), .P_ADDR_WIDTH(AW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .in_valid_i(in_valid), .in_data_i(in_data), .in_ready_o(in_ready),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
    .count_o(count), .ovf_o(ovf),
    .ram_wr_o(ram_wr), .ram_addr_wr_o(ram_addr_wr), .ram_data_wr_o(ram_data_wr),
    .ram_rd_o(ram_rd), .ram_addr_rd_o(ram_addr_rd), .ram_data_i(ram_q)
  );

  // Single-clock RAM, registered read, no read-during-write forwarding.
  always @(posedge clk) begin
    if (ram_wr) mem[ram_addr_wr] <= ram_data_wr;
    if (ram_rd) ram_q <= mem[ram_addr_rd];
  end

  int            checks = 0;
  int            failures = 0;
  logic [DW-1:0] q[$];
  logic          m_ovf = 1'b0;
  logic [AW-1:0] wr_idx = '0;
  int            npop = 0;
  int            pushed = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at the falling edge: compare against the model, update it, advance to just past the rising edge.
  task automatic step();
    bit exp_push;
    exp_push = in_valid && !flush && (q.size() < DEPTH);
    chk("count", 32'(count), q.size());
    chk("in_ready", 32'(in_ready), 32'(q.size() < DEPTH));
    chk("ovf", 32'(ovf), 32'(m_ovf));
    chk("ram_wr", 32'(ram_wr), 32'(exp_push));
    chk("valid_without_data", 32'(out_valid && q.size() == 0), 0);
    if (exp_push) begin
      chk("wr_addr", 32'(ram_addr_wr), 32'(wr_idx));
      chk("wr_data", 32'(ram_data_wr), 32'(in_data));
    end
    if (out_valid && out_ready && !flush && q.size() != 0) begin
      chk("pop_data", 32'(out_data), 32'(q[0]));
      void'(q.pop_front());
      npop++;
    end
    if (flush) begin
      q.delete();
      wr_idx = '0;
      m_ovf = 1'b0;
    end else begin
      if (in_valid && !exp_push) m_ovf = 1'b1;
      if (exp_push) begin
        q.push_back(in_data);
        wr_idx++;
        pushed++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 50 && (q.size() != 0 || out_valid); k++) begin
      @(negedge clk);
      step();
    end
    chk("drain_empty", q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int s_pop, s_push;
    // Reset values, with a push request and a ready consumer both held high.
    in_valid = 1'b1; in_data = 8'h11; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_ram_wr", 32'(ram_wr), 0);
    chk("rst_ram_rd", 32'(ram_rd), 0);
    chk("rst_ovf", 32'(ovf), 0);
    in_valid = 1'b0; out_ready = 1'b0; rst_n = 1'b1;

    // Fill latency.
    in_valid = 1'b1; in_data = 8'hA5;
    @(negedge clk);
    chk("lat_t_wr", 32'(ram_wr), 1);
    chk("lat_t_addr", 32'(ram_addr_wr), 0);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("lat_t1_rd", 32'(ram_rd), 1);
    chk("lat_t1_addr", 32'(ram_addr_rd), 0);
    step();
    @(negedge clk);
    chk("lat_t2_valid", 32'(out_valid), 1);
    chk("lat_t2_data", 32'(out_data), 32'h A5);
    chk("lat_t2_count", 32'(count), 1);
    step();
    drain();
    @(negedge clk);
    chk("empty_ready_valid", 32'(out_valid), 0);
    chk("empty_ready_rd", 32'(ram_rd), 0);
    step();

    // Full, overflow, no pop bypass on in_ready.
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      in_valid = 1'b1; in_data = DW'($urandom);
      @(negedge clk);
      step();
    end
    in_data = 8'hEE;
    @(negedge clk);
    chk("full_count", 32'(count), 16);
    chk("full_in_ready", 32'(in_ready), 0);
    step();
    @(negedge clk);
    chk("ovf_set", 32'(ovf), 1);
    chk("ovf_count", 32'(count), 16);
    step();
    out_ready = 1'b1;
    @(negedge clk);
    chk("full_pop_no_bypass", 32'(ram_wr), 0);
    step();
    in_valid = 1'b0;
    for (int k = 0; k < 40 && q.size() > 5; k++) begin
      @(negedge clk);
      step();
    end
    out_ready = 1'b0;
    @(negedge clk);
    step();

    // Flush with count 5 and a push pending.
    in_valid = 1'b1; in_data = 8'h77; flush = 1'b1;
    @(negedge clk);
    chk("flush_pre_count", 32'(count), 5);
    step();
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("flush_count", 32'(count), 0);
    chk("flush_valid", 32'(out_valid), 0);
    chk("flush_ovf", 32'(ovf), 0);
    step();
    in_valid = 1'b1; in_data = 8'h42;
    @(negedge clk);
    step();
    drain();

    // Streaming 0..99.
    s_pop = npop;
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      in_data = DW'(i);
      @(negedge clk);
      if (i > 0) chk("stream_count", 32'(count == 1 || count == 2), 1);
      if (i >= 2) chk("stream_gap", 32'(out_valid), 1);
      step();
    end
    drain();
    chk("stream_popped", npop - s_pop, 100);

    // Random valid/ready, 40 words, pointers wrap.
    s_pop = npop; s_push = pushed;
    for (int k = 0; k < 2000 && (npop - s_pop) < 40; k++) begin
      in_valid = ((pushed - s_push) < 40) ? 1'($urandom % 2) : 1'b0;
      in_data = DW'($urandom);
      out_ready = 1'($urandom % 2);
      @(negedge clk);
      step();
    end
    chk("wrap_popped", npop - s_pop, 40);
    drain();

    // Reset mid-stream.
    in_valid = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_data = DW'($urandom);
      @(negedge clk);
      step();
    end
    rst_n = 1'b0;
    #1;
    chk("mid_rst_count", 32'(count), 0);
    chk("mid_rst_valid", 32'(out_valid), 0);
    chk("mid_rst_in_ready", 32'(in_ready), 1);
    chk("mid_rst_ram_wr", 32'(ram_wr), 0);
    chk("mid_rst_ram_rd", 32'(ram_rd), 0);
    q.delete(); wr_idx = '0; m_ovf = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1; in_data = 8'h3C;
    @(negedge clk);
    chk("post_rst_push", 32'(ram_wr), 1);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    step();
    @(negedge clk);
    chk("post_rst_valid", 32'(out_valid), 1);
    chk("post_rst_data", 32'(out_data), 32'h3C);
    step();
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
